sobel_line_fifo: RTL and testbench
==================================

Name: sobel_line_fifo

Overview:
- Single-clock first-in first-out (FIFO) buffer, 8 bits wide and 4096 entries deep.
- Buffers pixel bytes between stages of the Sobel edge-detection pipeline (line buffering of greyscale data).
- Provides full/empty flags and programmable almost-full/almost-empty flags.
- Read data comes straight from the memory, with no extra output register.

Parameters:
- DATA_WIDTH, 8, width of the write and read data.
- DEPTH_WIDTH, 12, address width; depth = 2**DEPTH_WIDTH = 4096 entries.
- ALMOST_FULL_NUM, 1020, fill-count threshold for almost_full.
- ALMOST_EMPTY_NUM, 4, fill-count threshold for almost_empty.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- wr_data  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds 4096 entries.
- almost_full  out  1  fill count >= ALMOST_FULL_NUM.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read data.
- rd_empty  out  1  FIFO holds 0 entries.
- almost_empty  out  1  fill count <= ALMOST_EMPTY_NUM.

Behaviour:
- State:
  - write pointer and read pointer, each DEPTH_WIDTH+1 bits (extra wrap bit);
  - fill count, 0..4096;
  - 4096 x 8 memory;
  - rd_data register.
- Reset (rst=0 at a clock edge):
  - pointers = 0, count = 0, rd_data = 0;
  - rd_empty = 1, almost_empty = 1, wr_full = 0, almost_full = 0;
  - memory contents are not cleared;
  - a reset mid-operation discards all stored data at that edge.
- Write accept: wr_en=1 and wr_full=0.
  - mem[wr_ptr] <= wr_data; wr_ptr increments (wraps modulo 2**(DEPTH_WIDTH+1)).
  - wr_en while full is ignored: no pointer, count or memory change.
- Read accept: rd_en=1 and rd_empty=0.
  - rd_data <= mem[rd_ptr]; rd_ptr increments.
  - Data is valid on rd_data in the cycle after the accepting edge (1-cycle latency).
  - rd_en while empty is ignored; rd_data holds its last value.
- Simultaneous accepted read and write: both occur and the count is unchanged.
  - Full and empty are judged on the pre-edge state:
    - when full, only the read is accepted;
    - when empty, only the write is accepted (no write-through to rd_data).
- Count: +1 on write-only, -1 on read-only, unchanged otherwise.
- Flags: combinational decodes of the registered count/pointers, so they change the cycle after the accepting edge.
  - wr_full = (count == 4096), i.e. pointers equal except the MSB.
  - rd_empty = (count == 0).
  - almost_full = (count >= ALMOST_FULL_NUM).
  - almost_empty = (count <= ALMOST_EMPTY_NUM).
- Ordering: strict FIFO order; data is bit-exact; pointer wrap past entry 4095 is transparent to the user.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 20 cycles, then release.
  - Required: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
- Fill:
  - Stimulus: write 4097 consecutive cycles with data 0xFF, 0xFE, ... (decrementing mod 256).
  - Required: almost_empty drops after the 5th write; almost_full rises after the 1020th write; wr_full rises after the 4096th write; the 4097th write is dropped.
- Drain:
  - Stimulus: read 4097 consecutive cycles.
  - Required: rd_data one cycle after each accepted read is 0xFF, 0xFE, ... in order, with 0 errors; rd_empty rises after the 4096th read; the 4097th read is ignored and rd_data holds 0x00.
- Simultaneous read and write at mid-fill (count 100):
  - Stimulus: assert both for 50 cycles.
  - Required: count stays 100; data remains in order.
- Full plus read and write:
  - Stimulus: assert both on the same edge while full.
  - Required: read accepted, write dropped, count = 4095.
  - Stimulus: assert both on the same edge while empty.
  - Required: write accepted, rd_data unchanged, count = 1.
- Reset mid-stream:
  - Stimulus: with 2000 entries stored, assert rst=0 for one edge.
  - Required: rd_empty=1 the next cycle; a subsequent write/read returns the new data only.

Source files
------------

// File: rtl/sobel_line_fifo_if.sv
// Pixel-byte FIFO bus: write side, read side and status flags.
// Master drives requests and write data; slave (the FIFO) returns read data and flags.
interface sobel_line_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  wr_full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty
    );
endinterface

// File: rtl/sobel_line_fifo.sv
// Single-clock line-buffer FIFO for greyscale pixel bytes in the Sobel pipeline.
// Latency: rd_data valid one cycle after an accepted read; flags update the cycle after the accepting edge.
// Backpressure: writes while full and reads while empty are dropped; wr_full/rd_empty gate acceptance.
module sobel_line_fifo #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_WIDTH      = 12,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic             clk,
    input  logic             rst,
    sobel_line_fifo_if.slave bus
);
    localparam int CW = DEPTH_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_LVL = CW'(1 << DEPTH_WIDTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(ALMOST_FULL_NUM);
    localparam logic [CW-1:0] AE_LVL    = CW'(ALMOST_EMPTY_NUM);

    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem [1 << DEPTH_WIDTH];

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    // Full/empty come from the pre-edge state, so a read+write while full
    // only reads and a read+write while empty only writes.
    assign full   = (count == DEPTH_LVL);
    assign empty  = (count == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_q <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr[DEPTH_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.wr_full      = full;
    assign bus.rd_empty     = empty;
    assign bus.almost_full  = (count >= AF_LVL);
    assign bus.almost_empty = (count <= AE_LVL);
endmodule

// File: tb/tb_sobel_line_fifo.sv
// Directed-vector bench for sobel_line_fifo: hand-computed table plus model-checked multi-cycle sequences.
module tb_sobel_line_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;

    sobel_line_fifo_if #(.DATA_WIDTH(8)) bus ();

    sobel_line_fifo #(
        .DATA_WIDTH      (8),
        .DEPTH_WIDTH     (12),
        .ALMOST_FULL_NUM (1020),
        .ALMOST_EMPTY_NUM(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] wd;
        logic [7:0] rd;
        logic       empty;
        logic       ae;
        logic       full;
        logic       af;
    } vec_t;

    vec_t       tbl [15];
    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] q[$];
    logic [7:0] exp_rd;

    // Observed outputs packed as {rd_data, rd_empty, almost_empty, wr_full, almost_full}.
    function automatic logic [11:0] act();
        return {bus.rd_data, bus.rd_empty, bus.almost_empty, bus.wr_full, bus.almost_full};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {exp_rd, q.size() == 0, q.size() <= 4, q.size() == 4096, q.size() >= 1020};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got rd_data=%h e/ae/f/af=%b want rd_data=%h e/ae/f/af=%b",
                     name, got[11:4], got[3:0], want[11:4], want[3:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset(input int cycles);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_data = 8'h00;
        rst = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        exp_rd = 8'h00;
    endtask

    task automatic apply(input logic we, input logic re, input logic [7:0] wd);
        bus.wr_en = we;
        bus.rd_en = re;
        bus.wr_data = wd;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // One clock with the reference queue deciding acceptance from the pre-edge fill.
    task automatic do_cycle(input logic we, input logic re, input logic [7:0] wd, input string name);
        bit acc_w;
        bit acc_r;
        acc_w = we && (q.size() < 4096);
        acc_r = re && (q.size() > 0);
        apply(we, re, wd);
        if (acc_r) exp_rd = q.pop_front();
        if (acc_w) q.push_back(wd);
        check(name, act(), exp_vec());
    endtask

    task automatic drain_all(input int want, input string name);
        int n;
        n = 0;
        for (int k = 0; k < 5000; k++) begin
            if (bus.rd_empty) break;
            do_cycle(1'b0, 1'b1, 8'h00, name);
            n++;
        end
        check_int({name, "_count"}, n, want);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 8'hA5, 8'h00, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 8'h3C, 8'h00, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 8'h00, 8'hA5, 0, 1, 0, 0};
        tbl[3]  = '{1, 1, 8'h7E, 8'h3C, 0, 1, 0, 0};
        tbl[4]  = '{1, 1, 8'h11, 8'h7E, 0, 1, 0, 0};
        tbl[5]  = '{0, 1, 8'h00, 8'h11, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 8'h00, 8'h11, 1, 1, 0, 0};
        tbl[7]  = '{1, 1, 8'h99, 8'h11, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 8'h00, 8'h99, 1, 1, 0, 0};
        tbl[9]  = '{1, 0, 8'h01, 8'h99, 0, 1, 0, 0};
        tbl[10] = '{1, 0, 8'h02, 8'h99, 0, 1, 0, 0};
        tbl[11] = '{1, 0, 8'h03, 8'h99, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 8'h04, 8'h99, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 8'h05, 8'h99, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 8'h00, 8'h01, 0, 1, 0, 0};

        // Reset held for 20 cycles.
        do_reset(20);
        check("reset_state", act(), 12'h00C);

        // Hand-computed short sequences.
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].we, tbl[i].re, tbl[i].wd);
            check($sformatf("tbl[%0d]", i), act(),
                  {tbl[i].rd, tbl[i].empty, tbl[i].ae, tbl[i].full, tbl[i].af});
        end

        // Fill with 0xFF, 0xFE, ... for 4097 cycles; the last write is dropped.
        do_reset(2);
        for (int i = 0; i < 4097; i++) begin
            do_cycle(1'b1, 1'b0, 8'(255 - i), "fill");
        end
        check("fill_full", act(), {8'h00, 4'b0011});

        // Drain 4097 cycles; the last read is ignored and rd_data holds 0x00.
        for (int i = 0; i < 4097; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00, "drain");
        end
        check("drain_empty", act(), {8'h00, 4'b1100});

        // Simultaneous read+write at a fill of 100.
        do_reset(2);
        for (int i = 0; i < 100; i++) do_cycle(1'b1, 1'b0, 8'(i), "mid_fill");
        for (int i = 0; i < 50; i++) do_cycle(1'b1, 1'b1, 8'(i + 100), "mid_rw");
        drain_all(100, "mid_drain");

        // Read+write while full: only the read lands.
        do_reset(2);
        for (int i = 0; i < 4096; i++) do_cycle(1'b1, 1'b0, 8'(i * 7), "refill");
        do_cycle(1'b1, 1'b1, 8'h77, "full_rw");
        drain_all(4095, "full_rw_drain");

        // Read+write while empty: only the write lands, rd_data unchanged.
        do_cycle(1'b1, 1'b1, 8'h42, "empty_rw");
        drain_all(1, "empty_rw_drain");

        // Reset with 2000 entries stored discards them all.
        do_reset(2);
        for (int i = 0; i < 2000; i++) do_cycle(1'b1, 1'b0, 8'(i + 3), "pre_rst");
        do_reset(1);
        check("midrst_state", act(), 12'h00C);
        do_cycle(1'b1, 1'b0, 8'hC3, "post_rst_wr");
        do_cycle(1'b1, 1'b0, 8'h3C, "post_rst_wr");
        drain_all(2, "post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
